sm_subtractor: RTL and testbench

Pipelined sign-magnitude fixed-point subtractor computing c = a − b on N-bit operands (bit N−1 = sign, bits N−2:0 = magnitude). It is the inverse-direction companion of the combinational sign-magnitude adder and sits in the equalizer datapath, for example for the error term e = d − y. Unlike the adder, it is registered, uses valid/ready handshakes with backpressure, saturates on overflow and normalises negative zero.

---
 rtl/sm_subtractor.sv | 111 +++++++++++
 tb/tb_sm_subtractor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_subtractor.sv
// sm_subtractor: two-stage sign-magnitude subtractor c = a - b.
// Valid/ready handshake with backpressure, saturation and zero normalisation.
module sm_subtractor #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_c,
    output logic         out_ovf
);

    localparam int M = N - 1;

    typedef struct packed {
        logic         sa;
        logic         sb;
        logic [M-1:0] ma;
        logic [M-1:0] mb;
        logic         ge;
    } s1_t;

    s1_t          s1_d;
    s1_t          s1_q;
    logic         s1_valid;
    logic         s2_valid;
    logic         s1_adv;
    logic         s2_adv;
    logic         accept;
    logic [M-1:0] ma_in;
    logic [M-1:0] mb_in;
    logic [N-1:0] sum;
    logic [M-1:0] mag;
    logic         sgn;
    logic         ovf;
    logic [N-1:0] c_q;
    logic         ovf_q;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign accept   = in_valid && in_ready;

    assign ma_in = in_a[M-1:0];
    assign mb_in = in_b[M-1:0];

    // b is negated here; a zero magnitude always carries a + sign
    always_comb begin
        s1_d    = '0;
        s1_d.ma = ma_in;
        s1_d.mb = mb_in;
        s1_d.sa = in_a[N-1] && (ma_in != '0);
        s1_d.sb = !in_b[N-1] && (mb_in != '0);
        s1_d.ge = (ma_in >= mb_in);
    end

    always_comb begin
        sum = {1'b0, s1_q.ma} + {1'b0, s1_q.mb};
        mag = '0;
        sgn = 1'b0;
        ovf = 1'b0;
        unique case (1'b1)
            (s1_q.sa == s1_q.sb): begin
                sgn = s1_q.sa;
                if (sum[N-1]) begin
                    mag = '1;
                    ovf = 1'b1;
                end else begin
                    mag = sum[M-1:0];
                end
            end
            (s1_q.sa != s1_q.sb) && s1_q.ge: begin
                mag = s1_q.ma - s1_q.mb;
                sgn = s1_q.sa;
            end
            (s1_q.sa != s1_q.sb) && !s1_q.ge: begin
                mag = s1_q.mb - s1_q.ma;
                sgn = s1_q.sb;
            end
            default: ;
        endcase
        if (mag == '0) sgn = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (s2_adv)   s2_valid <= s1_valid;
            if (accept)   s1_q     <= s1_d;
            if (s1_adv) begin
                c_q   <= {sgn, mag};
                ovf_q <= ovf;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_c     = c_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sm_subtractor.sv
// tb_sm_subtractor: directed and random checks of sm_subtractor.
// Each task drives its own scenario and compares inline.
module tb_sm_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_c;
    logic        out_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    sm_subtractor #(.N(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // integer-domain reference: {ovf, c}
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        int va;
        int vb;
        int d;
        logic o;
        logic [15:0] c;
        va = a[15] ? -int'({17'd0, a[14:0]}) : int'({17'd0, a[14:0]});
        vb = b[15] ? -int'({17'd0, b[14:0]}) : int'({17'd0, b[14:0]});
        d = va - vb;
        o = (d > 32767) || (d < -32767);
        if (d > 32767) d = 32767;
        if (d < -32767) d = -32767;
        if (d < 0) c = {1'b1, 15'(-d)};
        else c = {1'b0, 15'(d)};
        return {o, c};
    endfunction

    // caller sits #1 after a rising edge with an empty pipeline
    task automatic test_vec(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] ec, input logic eo, input string nm);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s in_ready: got %b want 1", nm, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s early out_valid: got %b want 0", nm, out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_c !== ec || out_ovf !== eo) begin
            n_bad++;
            $display("FAIL %s: got v=%b c=%h ovf=%b want v=1 c=%h ovf=%b",
                     nm, out_valid, out_c, out_ovf, ec, eo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_c !== 16'h0000 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset outputs: got v=%b c=%h ovf=%b want 0 0000 0",
                     out_valid, out_c, out_ovf);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_sign_cases();
        test_vec(16'h0005, 16'h0003, 16'h0002, 1'b0, "pos_minus_pos");
        test_vec(16'h0003, 16'h0005, 16'h8002, 1'b0, "pos_minus_larger");
        test_vec(16'h8003, 16'h8005, 16'h0002, 1'b0, "neg_minus_neg");
        test_vec(16'h0004, 16'h8004, 16'h0008, 1'b0, "pos_minus_neg");
    endtask

    task automatic test_zero_norm();
        test_vec(16'h0004, 16'h0004, 16'h0000, 1'b0, "equal_zero");
        test_vec(16'h8000, 16'h0000, 16'h0000, 1'b0, "negzero_a");
        test_vec(16'h0000, 16'h8000, 16'h0000, 1'b0, "negzero_b");
    endtask

    task automatic test_saturation();
        test_vec(16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1, "sat_pos");
        test_vec(16'hC000, 16'h4000, 16'hFFFF, 1'b1, "sat_neg");
        test_vec(16'h4000, 16'hBFFF, 16'h7FFF, 1'b0, "max_no_sat");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_a = 16'h0001;
        in_b = 16'h0000;
        in_valid = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp accept1 in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_a = 16'h0002;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp accept2 in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_a = 16'h0003;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_c !== 16'h0001) begin
                n_bad++;
                $display("FAIL bp stall%0d: got rdy=%b v=%b c=%h want 0 1 0001",
                         i, in_ready, out_valid, out_c);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_c !== 16'h0001) begin
            n_bad++;
            $display("FAIL bp release: got rdy=%b c=%h want 1 0001", in_ready, out_c);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_c !== 16'h0002) begin
            n_bad++;
            $display("FAIL bp second: got v=%b c=%h want 1 0002", out_valid, out_c);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_c !== 16'h0003) begin
            n_bad++;
            $display("FAIL bp third: got v=%b c=%h want 1 0003", out_valid, out_c);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp drained: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] qa [100];
        logic [15:0] qb [100];
        logic [16:0] e;
        for (int i = 0; i < 100; i++) begin
            qa[i] = 16'($urandom);
            qb[i] = 16'($urandom);
            if (i % 7 == 0) qb[i][14:0] = qa[i][14:0];
            if (i % 11 == 0) qa[i][14:0] = 15'h7FF0 | 15'(i);
            if (i % 13 == 0) qb[i][14:0] = '0;
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 102; cyc++) begin
            if (cyc >= 2) begin
                e = model(qa[cyc-2], qb[cyc-2]);
                n_cmp++;
                if (out_valid !== 1'b1 || out_c !== e[15:0] || out_ovf !== e[16]) begin
                    n_bad++;
                    $display("FAIL b2b[%0d] %h-%h: got v=%b c=%h ovf=%b want v=1 c=%h ovf=%b",
                             cyc - 2, qa[cyc-2], qb[cyc-2], out_valid, out_c, out_ovf,
                             e[15:0], e[16]);
                end
            end
            if (cyc < 100) begin
                in_a = qa[cyc];
                in_b = qb[cyc];
                in_valid = 1'b1;
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b in_ready[%0d]: got %b want 1", cyc, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b drained: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_a = 16'h0007;
        in_b = 16'h0002;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid full: got v=%b rdy=%b want 1 0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_c !== 16'h0000 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL mid reset: got v=%b c=%h ovf=%b want 0 0000 0",
                     out_valid, out_c, out_ovf);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid release: got rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
        test_vec(16'h0009, 16'h0001, 16'h0008, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_sign_cases();
        test_zero_norm();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
